reset_sequencer: RTL and testbench

Parametrised reset controller for the single system clock domain. It combines a power-on asynchronous reset, an external reset request and a synchronous software reset into one reset source. It then releases NUM_OUTPUTS reset lines in a fixed order: a common hold time first, then a per-line stagger, so that clocking/PLL, sensor-interface and pipeline logic leave reset in sequence. It sits at the top level, between the board reset/button inputs and every subsystem reset.

---
 rtl/reset_sequencer.sv | 161 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset controller: merges POR, external request and software reset into one
// source, then releases NUM_OUTPUTS reset lines after a hold time and per-line stagger.
module reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int ASYNC_ASSERT   = 1,
  parameter int FILTER_CYCLES  = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int NUM_OUTPUTS    = 3,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_async_rst,
  input  logic                   i_rst_req,
  input  logic                   i_sw_rst,
  output logic [NUM_OUTPUTS-1:0] o_rst,
  output logic                   o_done,
  output logic [1:0]             o_cause
);

  localparam int MAXC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

  if (SYNC_STAGES < 2 || FILTER_CYCLES < 1 || HOLD_CYCLES < 1 || NUM_OUTPUTS < 1 ||
      STAGGER_CYCLES < 1 || (ASYNC_ASSERT != 0 && ASYNC_ASSERT != 1)) begin : g_bad_params
    $fatal(1, "reset_sequencer: illegal parameter value");
  end

  typedef enum logic [1:0] {ST_ASSERT, ST_HOLD, ST_STAGGER, ST_RUN} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_OUTPUTS-1:0] rst_q, rst_d;
  logic                   done_q, done_d;
  logic [1:0]             cause_q, cause_d;
  logic [SYNC_STAGES-1:0] por_pipe_q;
  logic                   por_s, req_s, src, out_arst;

  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) por_pipe_q <= '1;
    else             por_pipe_q <= {por_pipe_q[SYNC_STAGES-2:0], 1'b0};
  end
  assign por_s = por_pipe_q[SYNC_STAGES-1];

  if (ASYNC_ASSERT != 0) begin : g_req_async
    logic [SYNC_STAGES-1:0] req_pipe_q;
    // Set/clear flop: the request stretches itself through the pipe so release timing matches POR.
    always_ff @(posedge i_clk or posedge i_async_rst or posedge i_rst_req) begin
      if (i_async_rst)    req_pipe_q <= '0;
      else if (i_rst_req) req_pipe_q <= '1;
      else                req_pipe_q <= {req_pipe_q[SYNC_STAGES-2:0], 1'b0};
    end
    assign req_s = req_pipe_q[SYNC_STAGES-1];
  end else begin : g_req_sync
    localparam int FW = $clog2(FILTER_CYCLES) + 1;
    logic [SYNC_STAGES-1:0] req_pipe_q;
    logic [FW-1:0]          fcnt_q;
    logic                   req_sync;
    assign req_sync = req_pipe_q[SYNC_STAGES-1];
    always_ff @(posedge i_clk or posedge i_async_rst) begin
      if (i_async_rst) begin
        req_pipe_q <= '0;
        fcnt_q     <= '0;
      end else begin
        req_pipe_q <= {req_pipe_q[SYNC_STAGES-2:0], i_rst_req};
        if (!req_sync)                          fcnt_q <= '0;
        else if (fcnt_q != FW'(FILTER_CYCLES - 1)) fcnt_q <= fcnt_q + FW'(1);
      end
    end
    // The cycle in which req_sync first shows 1 counts as the first of the filter window.
    assign req_s = req_sync & (fcnt_q == FW'(FILTER_CYCLES - 1));
  end

  assign src      = por_s | req_s | i_sw_rst;
  assign out_arst = i_async_rst | ((ASYNC_ASSERT != 0) & i_rst_req);
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    cause_d = cause_q;
    if (src) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
      done_d  = 1'b0;
      if (state_q != ST_ASSERT)
        cause_d = por_s ? 2'b01 : (req_s ? 2'b10 : 2'b11);
    end else begin
      case (state_q)
        // ASSERT keeps cnt at 0, so its first quiet edge is hold edge 1.
        ST_ASSERT, ST_HOLD: begin
          if (cnt_inc == CW'(HOLD_CYCLES)) begin
            rst_d[0] = 1'b0;
            cnt_d    = '0;
            idx_d    = IW'(1);
            if (NUM_OUTPUTS == 1) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = ST_STAGGER;
            end
          end else begin
            cnt_d   = cnt_inc;
            state_d = ST_HOLD;
          end
        end
        ST_STAGGER: begin
          if (cnt_inc == CW'(STAGGER_CYCLES)) begin
            for (int unsigned k = 0; k < NUM_OUTPUTS; k++)
              if (k == 32'(idx_q)) rst_d[k] = 1'b0;
            cnt_d = '0;
            if (idx_q == IW'(NUM_OUTPUTS - 1)) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      cause_q <= 2'b01;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cause_q <= cause_d;
    end
  end

  always_ff @(posedge i_clk or posedge out_arst) begin
    if (out_arst) begin
      rst_q  <= '1;
      done_q <= 1'b0;
    end else begin
      rst_q  <= rst_d;
      done_q <= done_d;
    end
  end

  assign o_rst   = rst_q;
  assign o_done  = done_q;
  assign o_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default, filtered-request and single-output configurations.
module tb_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_arst, a_req, a_sw, a_done;
  logic [2:0] a_rst;
  logic [1:0] a_cause;
  logic       b_arst, b_req, b_sw, b_done;
  logic [2:0] b_rst;
  logic [1:0] b_cause;
  logic       c_arst, c_req, c_sw, c_done;
  logic [0:0] c_rst;
  logic [1:0] c_cause;

  reset_sequencer #(.SYNC_STAGES(2), .ASYNC_ASSERT(1), .FILTER_CYCLES(4), .HOLD_CYCLES(16),
                    .NUM_OUTPUTS(3), .STAGGER_CYCLES(4)) u_a (
    .i_clk(clk), .i_async_rst(a_arst), .i_rst_req(a_req), .i_sw_rst(a_sw),
    .o_rst(a_rst), .o_done(a_done), .o_cause(a_cause));

  reset_sequencer #(.SYNC_STAGES(2), .ASYNC_ASSERT(0), .FILTER_CYCLES(4), .HOLD_CYCLES(16),
                    .NUM_OUTPUTS(3), .STAGGER_CYCLES(4)) u_b (
    .i_clk(clk), .i_async_rst(b_arst), .i_rst_req(b_req), .i_sw_rst(b_sw),
    .o_rst(b_rst), .o_done(b_done), .o_cause(b_cause));

  reset_sequencer #(.SYNC_STAGES(2), .ASYNC_ASSERT(1), .FILTER_CYCLES(4), .HOLD_CYCLES(1),
                    .NUM_OUTPUTS(1), .STAGGER_CYCLES(4)) u_c (
    .i_clk(clk), .i_async_rst(c_arst), .i_rst_req(c_req), .i_sw_rst(c_sw),
    .o_rst(c_rst), .o_done(c_done), .o_cause(c_cause));

  int nvec = 0;
  int nerr = 0;
  int edge_n = 0;

  typedef struct {
    int         e;
    logic [2:0] rst;
    logic       done;
    logic [1:0] cause;
  } vec_t;
  vec_t tab[9];

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    a_arst = 1'b1; a_req = 1'b0; a_sw = 1'b0;
    b_arst = 1'b1; b_req = 1'b0; b_sw = 1'b0;
    c_arst = 1'b1; c_req = 1'b0; c_sw = 1'b0;

    tab[0] = '{1,  3'b111, 1'b0, 2'b01};
    tab[1] = '{2,  3'b111, 1'b0, 2'b01};
    tab[2] = '{17, 3'b111, 1'b0, 2'b01};
    tab[3] = '{18, 3'b110, 1'b0, 2'b01};
    tab[4] = '{21, 3'b110, 1'b0, 2'b01};
    tab[5] = '{22, 3'b100, 1'b0, 2'b01};
    tab[6] = '{25, 3'b100, 1'b0, 2'b01};
    tab[7] = '{26, 3'b000, 1'b1, 2'b01};
    tab[8] = '{27, 3'b000, 1'b1, 2'b01};

    // Reset state
    repeat (2) tick();
    chk("a_reset_rst",   32'(a_rst),   32'h7);
    chk("a_reset_done",  32'(a_done),  32'h0);
    chk("a_reset_cause", 32'(a_cause), 32'h1);
    chk("b_reset_rst",   32'(b_rst),   32'h7);
    chk("c_reset_rst",   32'(c_rst),   32'h1);

    // POR release sequence, table driven
    a_arst = 1'b0; b_arst = 1'b0; c_arst = 1'b0;
    edge_n = 0;
    for (int i = 0; i < 9; i++) begin
      run_to(tab[i].e);
      chk("por_rst",   32'(a_rst),   32'(tab[i].rst));
      chk("por_done",  32'(a_done),  32'(tab[i].done));
      chk("por_cause", 32'(a_cause), 32'(tab[i].cause));
    end
    chk("b_por_rst",  32'(b_rst),  32'h0);
    chk("b_por_done", 32'(b_done), 32'h1);
    chk("c_por_done", 32'(c_done), 32'h1);

    // Software reset in RUN
    a_sw = 1'b1;
    edge_n = -1;
    tick();
    chk("sw_e0_rst",   32'(a_rst),   32'h7);
    chk("sw_e0_done",  32'(a_done),  32'h0);
    chk("sw_e0_cause", 32'(a_cause), 32'h3);
    a_sw = 1'b0;
    run_to(15); chk("sw_e15_rst", 32'(a_rst), 32'h7);
    run_to(16); chk("sw_e16_rst", 32'(a_rst), 32'h6);
    run_to(19); chk("sw_e19_rst", 32'(a_rst), 32'h6);
    run_to(20); chk("sw_e20_rst", 32'(a_rst), 32'h4);
    run_to(23); chk("sw_e23_done", 32'(a_done), 32'h0);
    run_to(24); chk("sw_e24_rst", 32'(a_rst), 32'h0);
    chk("sw_e24_done", 32'(a_done), 32'h1);
    chk("sw_e24_cause", 32'(a_cause), 32'h3);

    // Asynchronous request glitch between edges
    a_req = 1'b1;
    #2;
    a_req = 1'b0;
    #1;
    chk("glitch_now_rst",  32'(a_rst),  32'h7);
    chk("glitch_now_done", 32'(a_done), 32'h0);
    edge_n = 0;
    run_to(1);  chk("glitch_e1_cause", 32'(a_cause), 32'h2);
    run_to(17); chk("glitch_e17_rst", 32'(a_rst), 32'h7);
    run_to(18); chk("glitch_e18_rst", 32'(a_rst), 32'h6);

    // Software reset landing on the edge that would release o_rst[1]
    run_to(21); chk("restart_e21_rst", 32'(a_rst), 32'h6);
    a_sw = 1'b1;
    tick();
    chk("restart_e22_rst",   32'(a_rst),   32'h7);
    chk("restart_e22_cause", 32'(a_cause), 32'h3);
    a_sw = 1'b0;
    run_to(37); chk("restart_e37_rst", 32'(a_rst), 32'h7);
    run_to(38); chk("restart_e38_rst", 32'(a_rst), 32'h6);
    run_to(46); chk("restart_e46_rst", 32'(a_rst), 32'h0);
    chk("restart_e46_done", 32'(a_done), 32'h1);

    // Filtered request: 3-cycle pulse must be ignored
    edge_n = 0;
    b_req = 1'b1;
    run_to(3);
    b_req = 1'b0;
    for (int e = 4; e <= 12; e++) begin
      run_to(e);
      chk("short_pulse_rst", 32'(b_rst), 32'h0);
    end
    chk("short_pulse_done", 32'(b_done), 32'h1);

    // Filtered request: 10-cycle pulse asserts at E6
    edge_n = 0;
    b_req = 1'b1;
    run_to(5);  chk("long_e5_rst", 32'(b_rst), 32'h0);
    run_to(6);  chk("long_e6_rst", 32'(b_rst), 32'h7);
    chk("long_e6_done",  32'(b_done),  32'h0);
    chk("long_e6_cause", 32'(b_cause), 32'h2);
    run_to(10);
    b_req = 1'b0;
    run_to(27); chk("long_e27_rst", 32'(b_rst), 32'h7);
    run_to(28); chk("long_e28_rst", 32'(b_rst), 32'h6);

    // Single output, HOLD_CYCLES=1: software reset in RUN
    c_sw = 1'b1;
    edge_n = -1;
    tick();
    chk("c_sw_e0_rst",   32'(c_rst),   32'h1);
    chk("c_sw_e0_done",  32'(c_done),  32'h0);
    chk("c_sw_e0_cause", 32'(c_cause), 32'h3);
    c_sw = 1'b0;
    tick();
    chk("c_sw_e1_rst",  32'(c_rst),  32'h0);
    chk("c_sw_e1_done", 32'(c_done), 32'h1);

    // Single output: POR together with software reset
    c_arst = 1'b1;
    c_sw   = 1'b1;
    #1;
    chk("c_por_now_rst",   32'(c_rst),   32'h1);
    chk("c_por_now_done",  32'(c_done),  32'h0);
    chk("c_por_now_cause", 32'(c_cause), 32'h1);
    repeat (2) tick();
    c_arst = 1'b0;
    edge_n = 0;
    tick();
    c_sw = 1'b0;
    run_to(2);
    chk("c_por_e2_rst",  32'(c_rst),  32'h1);
    chk("c_por_e2_done", 32'(c_done), 32'h0);
    run_to(3);
    chk("c_por_e3_rst",   32'(c_rst),   32'h0);
    chk("c_por_e3_done",  32'(c_done),  32'h1);
    chk("c_por_e3_cause", 32'(c_cause), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
